// File: rtl/axi_llc_pkg.sv
// Shared types and helpers for the LLC data SRAM access path.
//   llc_req_t      : request payload {we, addr, wdata, be} at the default LLC geometry
//   pend_cnt_width : width of a counter that must hold 0..depth inclusive
package axi_llc_pkg;

   localparam int unsigned LlcNumWords  = 1024;
   localparam int unsigned LlcDataWidth = 128;
   localparam int unsigned LlcByteWidth = 8;
   localparam int unsigned LlcAddrWidth = (LlcNumWords > 1) ? $clog2(LlcNumWords) : 1;
   localparam int unsigned LlcBeWidth   = (LlcDataWidth + LlcByteWidth - 1) / LlcByteWidth;

   typedef struct packed {
      logic                    we;
      logic [LlcAddrWidth-1:0] addr;
      logic [LlcDataWidth-1:0] wdata;
      logic [LlcBeWidth-1:0]   be;
   } llc_req_t;

   // Counter width able to represent every value from 0 up to and including depth.
   function automatic int unsigned pend_cnt_width(input int unsigned depth);
      return (depth > 0) ? $clog2(depth + 1) : 1;
   endfunction

endpackage

// File: rtl/axi_llc_data_resp_fifo.sv
// Synchronous response FIFO holding read data returned by the data SRAM.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_i, data_i    : write side
//   pop_i, data_o     : read side, data_o is the current head
//   full_o, empty_o   : occupancy flags
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axi_llc_data_resp_fifo
   import axi_llc_pkg::*;
#(
   parameter int unsigned Width = 128,
   parameter int unsigned Depth = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = pend_cnt_width(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];

   // Pointer wrap and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; contents are don't-care while empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && full_o && !pop_i))
      else $error("response FIFO overflow");

endmodule

// File: rtl/axi_llc_data_sram_ctrl.sv
// Access controller in front of one LLC data SRAM port.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   req_*           : valid/ready request channel from the LLC read/write units
//   resp_*          : valid/ready read response channel
//   sram_*          : SRAM macro port, request driven in the same cycle as the handshake
// Reads take a credit from a pending counter (queued + in flight) so the response
// FIFO can always absorb returning data; writes bypass admission and return nothing.
module axi_llc_data_sram_ctrl
   import axi_llc_pkg::*;
#(
   parameter int unsigned NumWords  = LlcNumWords,
   parameter int unsigned DataWidth = LlcDataWidth,
   parameter int unsigned ByteWidth = LlcByteWidth,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RespDepth = 3,
   parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [DataWidth-1:0] resp_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   localparam int unsigned PendW = pend_cnt_width(RespDepth);

   if (Latency < 1) begin : g_bad_latency
      $error("Latency must be at least 1");
   end
   if (RespDepth < 1) begin : g_bad_depth
      $error("RespDepth must be at least 1");
   end

   logic [PendW-1:0]   pend_q, pend_d;
   logic [Latency-1:0] pipe_q, pipe_d;
   logic               rd_hs, pop, push, fifo_full, fifo_empty;

   // Credit check uses only registered state, so resp_ready_i never reaches req_ready_o.
   assign req_ready_o  = req_we_i | (pend_q < PendW'(RespDepth));
   assign sram_req_o   = req_valid_i & req_ready_o;
   assign sram_we_o    = sram_req_o & req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = req_be_i;

   assign rd_hs        = sram_req_o & ~req_we_i;
   assign push         = pipe_q[Latency-1];
   assign resp_valid_o = ~fifo_empty;
   assign pop          = resp_valid_o & resp_ready_i;

   // Pending credits and read-valid shift register.
   always_comb begin
      pend_d = pend_q;
      pipe_d = '0;
      case ({rd_hs, pop})
         2'b10:   pend_d = pend_q + PendW'(1);
         2'b01:   pend_d = pend_q - PendW'(1);
         default: pend_d = pend_q;
      endcase
      pipe_d[0] = rd_hs;
      for (int i = 1; i < int'(Latency); i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= '0;
         pipe_q <= '0;
      end else begin
         pend_q <= pend_d;
         pipe_q <= pipe_d;
      end
   end

   axi_llc_data_resp_fifo #(
      .Width (DataWidth),
      .Depth (RespDepth)
   ) i_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (sram_rdata_i),
      .pop_i   (pop),
      .data_o  (resp_rdata_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   a_pend_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      pend_q <= PendW'(RespDepth))
      else $error("pending counter above response depth");

   a_push_room: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && fifo_full && !pop))
      else $error("read data returned with no free response slot");

endmodule
